// File: rtl/display_scanner_pkg.sv
// Shared constants and types for the 4-digit 7-segment display scanner.
package display_scanner_pkg;

    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic       DP_OFF  = 1'b1;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef logic [1:0] dig_idx_t;

    typedef enum logic {
        ST_GUARD,
        ST_SHOW
    } an_state_e;

    function automatic logic [3:0] nibble(
        input logic [15:0] word,
        input dig_idx_t    i
    );
        return word[{i, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Parameterised prescaler: counts enabled cycles 0..N-1, one-cycle tick on the last.
module tick_divider #(
    parameter int N = 10,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tick
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        tick  = en && (cnt_q == W'(N - 1));
        cnt_d = cnt_q;
        if (tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed driver for a 4-digit common-anode display with guard
// interval, per-frame digit snapshot, blanking and blinking colon.
module display_scanner
    import display_scanner_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int SCAN_HZ     = 1000,
    parameter int GUARD       = 16,
    parameter int BLINK_SLOTS = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] digits,
    input  logic [3:0]  blank_mask,
    input  logic        colon_en,
    output logic [3:0]  dec_in,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame_start
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BLK_W = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;

    logic [PRE_W-1:0] pre;
    logic [PRE_W-1:0] pre_nxt;
    logic             slot_tick;
    logic [BLK_W-1:0] unused_blink_cnt;
    logic             blink_wrap;

    tick_divider #(
        .N (DIV),
        .W (PRE_W)
    ) u_slot_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .cnt   (pre),
        .tick  (slot_tick)
    );

    tick_divider #(
        .N (BLINK_SLOTS),
        .W (BLK_W)
    ) u_blink_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (slot_tick),
        .cnt   (unused_blink_cnt),
        .tick  (blink_wrap)
    );

    dig_idx_t    idx_q, idx_d;
    logic [15:0] snap_q, snap_d;
    logic        colon_ph_q, colon_ph_d;
    an_state_e   state_q, state_d;
    logic [3:0]  an_q, an_d;
    logic [3:0]  dec_q, dec_d;
    logic        dp_q, dp_d;
    logic        fs_q, fs_d;
    logic [3:0]  cur;
    logic        blank;

    // Outputs are computed from next-state values so an, dec_in and dp
    // always move together with the slot they belong to.
    always_comb begin
        pre_nxt    = slot_tick ? '0 : pre + PRE_W'(1);
        idx_d      = slot_tick ? idx_q + 2'd1 : idx_q;
        fs_d       = slot_tick && (idx_q == 2'd3);
        snap_d     = fs_d ? digits : snap_q;
        colon_ph_d = colon_ph_q ^ blink_wrap;

        state_d = state_q;
        unique case (state_q)
            ST_GUARD: if (pre_nxt >= PRE_W'(GUARD)) state_d = ST_SHOW;
            ST_SHOW:  if (pre_nxt < PRE_W'(GUARD)) state_d = ST_GUARD;
            default:  state_d = ST_GUARD;
        endcase

        cur   = nibble(snap_d, idx_d);
        blank = blank_mask[idx_d] || (cur > BCD_MAX);
        dec_d = cur;
        an_d  = AN_OFF;
        dp_d  = DP_OFF;
        if (state_d == ST_SHOW) begin
            if (!blank) begin
                an_d = ~(4'b0001 << idx_d);
            end
            if (colon_en && colon_ph_d && (idx_d == 2'd2)) begin
                dp_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            snap_q     <= '0;
            colon_ph_q <= 1'b0;
            state_q    <= ST_GUARD;
            an_q       <= AN_OFF;
            dec_q      <= '0;
            dp_q       <= DP_OFF;
            fs_q       <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            snap_q     <= snap_d;
            colon_ph_q <= colon_ph_d;
            state_q    <= state_d;
            an_q       <= an_d;
            dec_q      <= dec_d;
            dp_q       <= dp_d;
            fs_q       <= fs_d;
        end
    end

    assign an          = an_q;
    assign dec_in      = dec_q;
    assign dp          = dp_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner with DIV=10, GUARD=2, BLINK_SLOTS=10.
module tb_display_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digits = 16'h0000;
    logic [3:0]  blank_mask = 4'b0000;
    logic        colon_en = 1'b0;
    logic [3:0]  dec_in;
    logic [3:0]  an;
    logic        dp;
    logic        frame_start;

    int n_tests = 0;
    int n_fail  = 0;
    int first_fs = -1;
    int lo[4] = '{default: 0};
    int all_off = 0;
    int blank1 = 0;
    int blank3 = 0;
    int dp_lo = 0;

    display_scanner #(
        .CLK_HZ      (1000),
        .SCAN_HZ     (100),
        .GUARD       (2),
        .BLINK_SLOTS (10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digits      (digits),
        .blank_mask  (blank_mask),
        .colon_en    (colon_en),
        .dec_in      (dec_in),
        .an          (an),
        .dp          (dp),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) step();
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_dec", 32'(dec_in), 32'h0);
        chk("rst_fs", 32'(frame_start), 32'h0);
        rst_n    = 1'b1;
        colon_en = 1'b1;
        digits   = 16'h1234;

        // k counts clock edges since reset release; slot = k/10, pre = k%10.
        for (int k = 1; k <= 305; k++) begin
            step();
            if (frame_start && first_fs < 0) first_fs = k;
            if (k >= 40 && k <= 79) begin
                for (int b = 0; b < 4; b++) if (!an[b]) lo[b]++;
                if (an == 4'hF) all_off++;
            end
            if (k >= 130 && k <= 139 && !an[1]) blank1++;
            if (k >= 150 && k <= 159 && !an[3]) blank3++;
            if (k >= 160 && k <= 199 && !dp) dp_lo++;
            case (k)
                1:   chk("guard0_an", 32'(an), 32'hF);
                2: begin
                    chk("show0_an", 32'(an), 32'hE);
                    chk("show0_dec", 32'(dec_in), 32'h0);
                end
                5:   chk("pre_frame_dp", 32'(dp), 32'h1);
                40: begin
                    chk("wrap1_fs", 32'(frame_start), 32'h1);
                    chk("wrap1_dec", 32'(dec_in), 32'h4);
                    chk("wrap1_an", 32'(an), 32'hF);
                end
                41: begin
                    chk("first_fs_lat", 32'(first_fs), 32'd40);
                    chk("fs_pulse_end", 32'(frame_start), 32'h0);
                end
                45: begin
                    chk("s0_dec", 32'(dec_in), 32'h4);
                    chk("s0_an", 32'(an), 32'hE);
                end
                55: begin
                    chk("s1_dec", 32'(dec_in), 32'h3);
                    chk("s1_an", 32'(an), 32'hD);
                    digits = 16'h5678;
                end
                65: begin
                    chk("tear_s2_dec", 32'(dec_in), 32'h2);
                    chk("tear_s2_an", 32'(an), 32'hB);
                    chk("ph0_dp", 32'(dp), 32'h1);
                end
                75: begin
                    chk("tear_s3_dec", 32'(dec_in), 32'h1);
                    chk("tear_s3_an", 32'(an), 32'h7);
                end
                80: begin
                    for (int b = 0; b < 4; b++)
                        chk($sformatf("an%0d_low_cnt", b), 32'(lo[b]), 32'd8);
                    chk("an_off_cnt", 32'(all_off), 32'd8);
                    chk("wrap2_fs", 32'(frame_start), 32'h1);
                    chk("wrap2_dec", 32'(dec_in), 32'h8);
                end
                95:  chk("f2_s1_dec", 32'(dec_in), 32'h7);
                100: chk("blink_guard_dp", 32'(dp), 32'h1);
                101: chk("blink_guard1_dp", 32'(dp), 32'h1);
                102: chk("blink_show_dp", 32'(dp), 32'h0);
                105: chk("f2_s2_dec", 32'(dec_in), 32'h6);
                115: chk("f2_s3_dec", 32'(dec_in), 32'h5);
                116: digits = 16'h02B1;
                125: begin
                    chk("f3_s0_dec", 32'(dec_in), 32'h1);
                    chk("f3_s0_an", 32'(an), 32'hE);
                    blank_mask = 4'b1000;
                end
                135: begin
                    chk("bad_bcd_dec", 32'(dec_in), 32'hB);
                    chk("bad_bcd_an", 32'(an), 32'hF);
                    chk("s1_colon_dp", 32'(dp), 32'h1);
                end
                145: begin
                    chk("f3_s2_an", 32'(an), 32'hB);
                    chk("f3_s2_dp", 32'(dp), 32'h0);
                end
                159: colon_en = 1'b0;
                160: begin
                    chk("bcd_blank_lows", 32'(blank1), 32'd0);
                    chk("mask_blank_lows", 32'(blank3), 32'd0);
                end
                199: begin
                    chk("colon_off_lows", 32'(dp_lo), 32'd0);
                    colon_en = 1'b1;
                end
                200: begin
                    chk("coinc_fs", 32'(frame_start), 32'h1);
                    chk("coinc_dec", 32'(dec_in), 32'h1);
                    chk("coinc_an", 32'(an), 32'hF);
                end
                225: chk("ph_after_coinc_dp", 32'(dp), 32'h1);
                305: begin
                    chk("ph_on_again_dp", 32'(dp), 32'h0);
                    chk("pre_rst_an", 32'(an), 32'hB);
                    chk("pre_rst_dec", 32'(dec_in), 32'h2);
                end
                default: ;
            endcase
        end

        rst_n = 1'b0;
        #1;
        chk("async_rst_an", 32'(an), 32'hF);
        chk("async_rst_dp", 32'(dp), 32'h1);
        chk("async_rst_dec", 32'(dec_in), 32'h0);
        chk("async_rst_fs", 32'(frame_start), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/display_scanner.md
# display_scanner

Time-multiplexing driver for the four-digit common-anode 7-segment display of the alarm clock. It takes four BCD digits (HH:MM) from the timekeeping logic and snapshots them once per scan frame. It presents one digit at a time on `dec_in` to the 7-segment decoder and drives the matching active-low anode, with a guard interval between digits to prevent ghosting. It also generates the blinking colon (decimal point of digit 2) and handles per-digit blanking.

## Interface
- `CLK_HZ`, 100_000_000, input clock frequency.
- `SCAN_HZ`, 1000, digit-slot rate in Hz; one slot lasts `DIV = CLK_HZ/SCAN_HZ` cycles. Requires `DIV >= GUARD+2`.
- `GUARD`, 16, cycles at the start of each slot with all anodes off.
- `BLINK_SLOTS`, 500, colon toggles every `BLINK_SLOTS` slot ticks.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `digits`  in  16  packed BCD `{d3,d2,d1,d0}`; `d3` is the leftmost (hours tens).
- `blank_mask`  in  4  bit i = 1 forces digit i dark.
- `colon_en`  in  1  1 = colon blinks; 0 = colon off.
- `dec_in`  out  4  BCD code to the 7-segment decoder.
- `an`  out  4  anode enables, active-low; bit i drives digit i.
- `dp`  out  1  decimal point, active-low; lit only while digit 2 is active and the colon phase is on.
- `frame_start`  out  1  one-cycle pulse when a new snapshot is taken.

## Operation
- **Prescaler.** `pre` counts 0..DIV-1 and wraps. A slot tick occurs when `pre == DIV-1`.
- **Digit index.** `idx` (2 bits) advances on each slot tick through 0→1→2→3→0.
- **Snapshot.** On the slot tick where `idx` wraps 3→0, `snap <= digits` and `frame_start` pulses in the same cycle. Input changes mid-frame are never visible until the next frame, so there is no tearing.
- **Digit output.** `dec_in = snap[idx]`, registered.
- **Anode state machine** (two states per slot):
  - GUARD: `pre < GUARD`, `an = 4'b1111`.
  - SHOW: `pre >= GUARD`, `an = ~(4'b0001 << idx)`, unless the digit is blanked.
- **Blanking.** A digit is blanked, with its anode held off during SHOW, when `blank_mask[idx]` is 1 or `snap[idx] > 9`. The decoder only defines codes 0–9, so codes above 9 must never be displayed.
- **Colon blink.**
  - `blink_cnt` counts slot ticks 0..BLINK_SLOTS-1. On wrap, `colon_ph` toggles.
  - `dp = ~(colon_en & colon_ph & SHOW & idx==2)`.
  - When `colon_en` is 0, `colon_ph` keeps running but `dp` stays 1.
- **Reset state.** `rst_n` low, asynchronously at any time including mid-slot, sets:
  - `pre=0`, `idx=0`, `snap=0`, `blink_cnt=0`, `colon_ph=0`
  - `an=4'b1111`, `dec_in=0`, `dp=1`, `frame_start=0`.
- **First frame after reset.** `idx=0` and `snap=0`. The first snapshot is taken at the first 3→0 wrap. Until then digit 0 shows "0" unless masked.

## Timing
- All outputs are registered. `an`, `dec_in` and `dp` change in the same cycle, so a digit never appears with a stale code.
- **Slot boundary.** The cycle after a slot tick has `pre=0`, the new `idx`, the new `dec_in`, and `an=1111`. Digit i's anode goes low at `pre == GUARD` of that slot.
- **Latency.** A `digits` change becomes visible at the next frame boundary: at most `4*DIV` cycles plus 1 register stage.
- `frame_start` is asserted in the cycle where `idx` becomes 0.
- **Simultaneous events.** A slot tick, frame wrap and blink wrap may coincide; all updates happen in that same cycle.
- **Input timing.** `blank_mask` and `colon_en` are sampled live, not snapshotted, and take effect one cycle after they change.

## Structure
- A shared package holds:
  - the active-low constants `AN_OFF = 4'b1111` and `DP_OFF = 1'b1`;
  - the BCD limit `BCD_MAX = 9`;
  - a 2-bit digit-index typedef.
- One natural sub-module is `tick_divider`, a parameterised prescaler that outputs a one-cycle tick every N cycles. It is instantiated twice: once for the slot rate and once, in slot-tick units, for the blink rate.
- The 7-segment decoder sits downstream and is instantiated at top level, not inside this block.

## Test plan
Bench parameters: `CLK_HZ=1000`, `SCAN_HZ=100` (DIV=10), `GUARD=2`, `BLINK_SLOTS=10`.
1. **Reset.** Assert `rst_n=0` mid-slot → `an=1111`, `dp=1`, `dec_in=0` in the same cycle. Release → `idx=0`, and the first `frame_start` pulse occurs 40 cycles later.
2. **Scan order.** `digits=16'h1234` after the snapshot → `dec_in` sequence is 4,3,2,1. `an` goes 1110, 1101, 1011, 0111, each low for 8 of every 10 cycles, with 2 cycles of 1111 between slots.
3. **Tearing.** Change `digits` from `16'h1234` to `16'h5678` while `idx=1` → `dec_in` shows 2 and then 1 for the rest of the frame; 8,7,6,5 appear after the next `frame_start`.
4. **Blanking.** `blank_mask=4'b1000` with `d3=0` → `an[3]` never goes low. Set `d1=4'hB` → `an[1]` stays high for the entire slot.
5. **Colon.** `colon_en=1` → `dp=0` only during SHOW of digit 2, on alternate 10-slot periods. `colon_en=0` → `dp` stays constantly 1.
6. **Wrap coincidence.** A frame wrap and a blink wrap in the same cycle → `frame_start=1`, `colon_ph` toggles, and `idx` becomes 0, all in one cycle.
